// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO: FSM state encoding and
// default sizing used by both the top level and the byte storage.
package uart_pkg;

    localparam int DEFAULT_DEPTH      = 8;
    localparam int DEFAULT_GAP_CYCLES = 12;
    localparam int BYTE_W             = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte queue with occupancy count; writes into a full queue are
// dropped and flagged with a one-cycle overflow pulse.
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
)
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en_i,
    input  logic [BYTE_W-1:0]          wr_data_i,
    input  logic                       rd_en_i,
    output logic [BYTE_W-1:0]          rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              push, pop;

    // Full is judged on the registered count, so a pop in the same cycle
    // does not rescue a write that arrives while full.
    always_comb begin
        push       = wr_en_i && (count_q != FULL_COUNT);
        pop        = rd_en_i && (count_q != '0);
        overflow_d = wr_en_i && (count_q == FULL_COUNT);
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o  = mem_q[rd_ptr_q];
    assign full_o     = (count_q == FULL_COUNT);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers bytes for a UART transmitter and paces launches: one tx_start per
// byte, hold the byte until tx_done, then idle for GAP_CYCLES clocks.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
)
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [BYTE_W-1:0]          wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       tx_start,
    output logic [BYTE_W-1:0]          tx_data,
    input  logic                       tx_done,
    output logic                       busy
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    tx_state_e         state_q, state_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic [BYTE_W-1:0] fifo_head;
    logic              fifo_empty;
    logic              fifo_pop;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .rd_en_i    (fifo_pop),
        .rd_data_o  (fifo_head),
        .full_o     (full),
        .empty_o    (fifo_empty),
        .count_o    (count),
        .overflow_o (overflow)
    );

    // The head byte is captured on the IDLE->LAUNCH edge so it is already
    // on tx_data during the tx_start cycle; the pop happens at LAUNCH's end.
    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        tx_data_d = tx_data_q;
        fifo_pop  = 1'b0;
        tx_start  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d   = LAUNCH;
                    tx_data_d = fifo_head;
                end
            end
            LAUNCH: begin
                tx_start = 1'b1;
                fifo_pop = 1'b1;
                state_d  = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    state_d = GAP;
                    gap_d   = '0;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gap_q     <= '0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign empty   = fifo_empty;
    assign tx_data = tx_data_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random traffic, all checked
// every cycle against a queue-and-timestamp model of the launch rules.
module tb_uart_tx_fifo;

    localparam int DEPTH = 8;
    localparam int GAP   = 12;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          tx_done = 1'b0;
    logic          full, empty, overflow, tx_start, busy;
    logic [CW-1:0] count;
    logic [7:0]    tx_data;

    uart_tx_fifo #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [7:0] mq[$];
    int         mStamp[$];
    bit         modelValid = 1'b0;
    bit         inFlight = 1'b0;
    bit         ovfPending = 1'b0;
    int         launchCycle = 0;
    int         lastDone = -1000;
    int         earliestLaunch = 0;
    logic [7:0] lastTx = 8'h00;

    logic [7:0] launchData[$];
    int         launchCyc[$];
    int         doneCyc[$];

    int doneDelay   = 50;
    int xmitTimer   = 0;
    int spuriousPct = 0;

    function automatic void compareField(string name, logic [31:0] actual, logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
        end
    endfunction

    // A byte launches once the sender is free, the post-done gap has elapsed,
    // and the oldest stored byte was written at least two cycles earlier.
    function automatic bit launchNow();
        return modelValid && !inFlight && (cyc >= earliestLaunch) &&
               (mq.size() > 0) && (mStamp[0] <= cyc - 2);
    endfunction

    task automatic checkOutput();
        bit         st;
        logic [7:0] expData;
        st      = launchNow();
        expData = st ? mq[0] : lastTx;
        compareField("count",    count,    mq.size());
        compareField("empty",    empty,    mq.size() == 0);
        compareField("full",     full,     mq.size() == DEPTH);
        compareField("overflow", overflow, ovfPending);
        compareField("tx_start", tx_start, st);
        compareField("tx_data",  tx_data,  expData);
        compareField("busy",     busy,     st || inFlight || (cyc <= lastDone + GAP));
    endtask

    task automatic stepModel();
        int sz;
        bit st;
        if (rst) begin
            mq.delete();
            mStamp.delete();
            modelValid     = 1'b1;
            inFlight       = 1'b0;
            ovfPending     = 1'b0;
            lastTx         = 8'h00;
            lastDone       = -1000;
            earliestLaunch = cyc + 2;
        end else if (modelValid) begin
            sz         = mq.size();
            st         = launchNow();
            ovfPending = wr_en && (sz == DEPTH);
            if (st) begin
                lastTx = mq.pop_front();
                void'(mStamp.pop_front());
                inFlight    = 1'b1;
                launchCycle = cyc;
            end else if (inFlight && (cyc > launchCycle) && tx_done) begin
                inFlight       = 1'b0;
                lastDone       = cyc;
                earliestLaunch = cyc + GAP + 2;
            end
            if (wr_en && (sz < DEPTH)) begin
                mq.push_back(wr_data);
                mStamp.push_back(cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput();
        end
        if (tx_start === 1'b1) begin
            launchData.push_back(tx_data);
            launchCyc.push_back(cyc);
        end
        if (tx_done === 1'b1) begin
            doneCyc.push_back(cyc);
        end
        stepModel();
        cyc++;
    end

    // One cycle of stimulus; also plays the transmitter, answering each
    // tx_start with tx_done doneDelay cycles later.
    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r);
        bit dn;
        @(posedge clk);
        #1;
        dn = 1'b0;
        if (tx_start === 1'b1) begin
            xmitTimer = doneDelay;
        end else if (xmitTimer > 0) begin
            xmitTimer--;
            dn = (xmitTimer == 0);
        end else if (spuriousPct > 0 && $urandom_range(99) < spuriousPct) begin
            dn = 1'b1;
        end
        if (r) begin
            xmitTimer = 0;
        end
        wr_en   = w;
        wr_data = d;
        rst     = r;
        tx_done = dn;
    endtask

    task automatic waitUntilIdle(input int budget, input string name);
        int n;
        n = 0;
        while (!(busy === 1'b0 && empty === 1'b1) && n < budget) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            n++;
        end
        compareField({name, " idle reached"}, busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1);

        // Single byte: reset values, launch two cycles after the write.
        applyStimulus(1'b1, 8'hA5, 1'b0);
        compareField("rst count",    count,    0);
        compareField("rst empty",    empty,    1);
        compareField("rst full",     full,     0);
        compareField("rst busy",     busy,     0);
        compareField("rst tx_start", tx_start, 0);
        compareField("rst tx_data",  tx_data,  8'h00);
        compareField("rst overflow", overflow, 0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        compareField("A5 not early", tx_start, 0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        compareField("A5 tx_start", tx_start, 1);
        compareField("A5 tx_data",  tx_data,  8'hA5);
        n = 1;
        while (busy === 1'b1 && n < 300) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            if (busy === 1'b1) n++;
        end
        compareField("A5 busy span", n, 1 + 50 + GAP);

        // Eight bytes back to back, transmitter answers 50 cycles after launch.
        launchData.delete(); launchCyc.delete(); doneCyc.delete();
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 8'(i), 1'b0);
        waitUntilIdle(1500, "seq");
        compareField("seq launches", launchData.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < launchData.size()) compareField($sformatf("seq data %0d", i), launchData[i], i + 1);
        end
        for (int i = 1; i < 8; i++) begin
            if (i < launchCyc.size() && i - 1 < doneCyc.size())
                compareField($sformatf("seq spacing %0d", i), launchCyc[i] - doneCyc[i - 1], 14);
        end

        // Fill while one byte is held in flight, then overflow with FF.
        doneDelay = 5000;
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0);
        applyStimulus(1'b1, 8'hFF, 1'b0);
        compareField("fill count", count, DEPTH);
        compareField("fill full",  full,  1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        compareField("ovf pulse",      overflow, 1);
        compareField("ovf count held", count,    DEPTH);
        applyStimulus(1'b0, 8'h00, 1'b0);
        compareField("ovf one cycle", overflow, 0);
        launchData.delete();
        doneDelay = 4;
        xmitTimer = 3;
        waitUntilIdle(1500, "drain");
        compareField("drain launches", launchData.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < launchData.size()) compareField($sformatf("drain data %0d", i), launchData[i], 8'h11 + i);
        end

        // Reset while waiting for tx_done with three bytes queued.
        doneDelay = 5000;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h21 + i), 1'b0);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
        compareField("pre-rst count", count, 3);
        compareField("pre-rst busy",  busy,  1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        compareField("mid rst empty",   empty,   1);
        compareField("mid rst count",   count,   0);
        compareField("mid rst busy",    busy,    0);
        compareField("mid rst tx_data", tx_data, 8'h00);
        launchData.delete();
        repeat (30) applyStimulus(1'b0, 8'h00, 1'b0);
        compareField("no launch after rst", launchData.size(), 0);
        doneDelay = 3;
        applyStimulus(1'b1, 8'h5A, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        compareField("post rst tx_start", tx_start, 1);
        compareField("post rst tx_data",  tx_data,  8'h5A);
        waitUntilIdle(200, "post rst");

        // Stray tx_done while idle and throughout the gap changes nothing.
        spuriousPct = 100;
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
        compareField("stray idle busy", busy, 0);
        launchCyc.delete();
        doneDelay = 2;
        applyStimulus(1'b1, 8'h3C, 1'b0);
        applyStimulus(1'b1, 8'hC3, 1'b0);
        waitUntilIdle(200, "stray gap");
        compareField("stray launches", launchCyc.size(), 2);
        if (launchCyc.size() == 2) compareField("stray spacing", launchCyc[1] - launchCyc[0], 2 + GAP + 2);

        // Random traffic with write bursts, stray dones and rare resets.
        spuriousPct = 10;
        for (int i = 0; i < 4000; i++) begin
            int wp;
            wp = ((i / 200) % 3 == 1) ? 90 : 35;
            doneDelay = $urandom_range(30, 1);
            applyStimulus($urandom_range(99) < wp, 8'($urandom), $urandom_range(999) == 0);
        end
        spuriousPct = 0;
        waitUntilIdle(1500, "final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
